// File: rtl/btn_event_decoder_if.sv
// rtl/btn_event_decoder_if.sv - debounced button level in, gesture event pulses out
interface btn_event_decoder_if;
    logic i_btn_stable;
    logic o_short_pulse;
    logic o_double_pulse;
    logic o_long_pulse;
    logic o_repeat_pulse;
    logic o_held;

    modport master (
        output i_btn_stable,
        input  o_short_pulse,
        input  o_double_pulse,
        input  o_long_pulse,
        input  o_repeat_pulse,
        input  o_held
    );

    modport slave (
        input  i_btn_stable,
        output o_short_pulse,
        output o_double_pulse,
        output o_long_pulse,
        output o_repeat_pulse,
        output o_held
    );
endinterface

// File: rtl/btn_event_decoder.sv
// rtl/btn_event_decoder.sv - per-button short/double/long/repeat gesture classifier
module btn_event_decoder #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 1000,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200,
    parameter int DCLICK_TICKS = 300,
    parameter int DCLICK_EN    = 1
) (
    input  logic                clk,
    input  logic                reset,
    btn_event_decoder_if.slave  bus
);
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int MAX_LR    = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int MAX_TICKS = (MAX_LR > DCLICK_TICKS) ? MAX_LR : DCLICK_TICKS;
    localparam int PW        = $clog2(DIV);
    localparam int TW        = $clog2(MAX_TICKS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_LONG_HOLD,
        ST_WAIT_SECOND,
        ST_SECOND_PRESS
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic            prev_q, prev_d;
    logic            armed_q, armed_d;
    logic            short_q, short_d;
    logic            double_q, double_d;
    logic            long_q, long_d;
    logic            repeat_q, repeat_d;
    logic            held_q, held_d;

    logic rise, fall, presc_wrap, long_hit, repeat_hit, dclick_hit, restart;

    // armed_q blocks a press that was already down when reset was released
    assign rise       = bus.i_btn_stable & ~prev_q & armed_q;
    assign fall       = ~bus.i_btn_stable & prev_q;
    assign presc_wrap = (presc_q == PW'(DIV - 1));
    assign long_hit   = presc_wrap && (tick_q == TW'(LONG_TICKS - 1));
    assign repeat_hit = presc_wrap && (tick_q == TW'(REPEAT_TICKS - 1));
    assign dclick_hit = presc_wrap && (tick_q == TW'(DCLICK_TICKS - 1));

    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        prev_d   = bus.i_btn_stable;
        armed_d  = armed_q | ~bus.i_btn_stable;

        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (fall) begin
                    if (DCLICK_EN != 0) begin
                        state_d = ST_WAIT_SECOND;
                    end else begin
                        state_d = ST_IDLE;
                        short_d = 1'b1;
                    end
                end else if (long_hit) begin
                    state_d = ST_LONG_HOLD;
                    long_d  = 1'b1;
                end
            end
            ST_LONG_HOLD: begin
                if (fall) state_d = ST_IDLE;
                else if (repeat_hit) repeat_d = 1'b1;
            end
            ST_WAIT_SECOND: begin
                if (rise) begin
                    state_d = ST_SECOND_PRESS;
                end else if (dclick_hit) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                end
            end
            ST_SECOND_PRESS: begin
                if (fall) begin
                    state_d  = ST_IDLE;
                    double_d = 1'b1;
                end else if (long_hit) begin
                    state_d = ST_LONG_HOLD;
                    long_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Timebase restarts on every transition and after each repeat
        restart = (state_d != state_q) | repeat_d;
        if (restart) begin
            presc_d = '0;
            tick_d  = '0;
        end else if (presc_wrap) begin
            presc_d = '0;
            tick_d  = (tick_q == {TW{1'b1}}) ? tick_q : tick_q + TW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
            tick_d  = tick_q;
        end

        held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG_HOLD) ||
                 (state_d == ST_SECOND_PRESS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            tick_q   <= '0;
            prev_q   <= 1'b0;
            armed_q  <= 1'b0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            prev_q   <= prev_d;
            armed_q  <= armed_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            held_q   <= held_d;
        end
    end

    assign bus.o_short_pulse  = short_q;
    assign bus.o_double_pulse = double_q;
    assign bus.o_long_pulse   = long_q;
    assign bus.o_repeat_pulse = repeat_q;
    assign bus.o_held         = held_q;
endmodule

// File: tb/tb_btn_event_decoder.sv
// tb/tb_btn_event_decoder.sv - bench for btn_event_decoder, double-click enabled and disabled copies
module tb_btn_event_decoder;
    localparam int LONG_C = 200;
    localparam int REP_C  = 50;
    localparam int DCL_C  = 60;

    localparam int P_IDLE  = 0;
    localparam int P_DOWN  = 1;
    localparam int P_HOLD  = 2;
    localparam int P_GAP   = 3;
    localparam int P_AGAIN = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn = 1'b0;

    btn_event_decoder_if bus_a ();
    btn_event_decoder_if bus_b ();
    assign bus_a.i_btn_stable = btn;
    assign bus_b.i_btn_stable = btn;

    btn_event_decoder #(
        .CLK_HZ(1000), .TICK_HZ(100), .LONG_TICKS(20), .REPEAT_TICKS(5),
        .DCLICK_TICKS(6), .DCLICK_EN(1)
    ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    btn_event_decoder #(
        .CLK_HZ(1000), .TICK_HZ(100), .LONG_TICKS(20), .REPEAT_TICKS(5),
        .DCLICK_TICKS(6), .DCLICK_EN(0)
    ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;

    // Reference model: gesture phases timed by absolute edge numbers
    int cyc = 0;
    int en_m[2] = '{1, 0};
    int ph[2], t_ent[2], t_rep[2];
    bit m_prev[2], m_arm[2];
    bit [4:0] exp_o[2];

    always @(posedge clk or negedge reset) begin
        bit b, rise, fall, s, d, l, r;
        int el;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                ph[i] = P_IDLE; m_prev[i] = 0; m_arm[i] = 0; exp_o[i] = '0;
                t_ent[i] = cyc; t_rep[i] = cyc;
            end
        end else begin
            cyc = cyc + 1;
            for (int i = 0; i < 2; i++) begin
                b = btn;
                rise = b && !m_prev[i] && m_arm[i];
                fall = !b && m_prev[i];
                el = cyc - t_ent[i];
                s = 0; d = 0; l = 0; r = 0;
                case (ph[i])
                    P_IDLE:  if (rise) begin ph[i] = P_DOWN; t_ent[i] = cyc; end
                    P_DOWN: begin
                        if (fall) begin
                            if (en_m[i] != 0) ph[i] = P_GAP; else begin ph[i] = P_IDLE; s = 1; end
                            t_ent[i] = cyc;
                        end else if (el == LONG_C) begin
                            ph[i] = P_HOLD; l = 1; t_ent[i] = cyc; t_rep[i] = cyc;
                        end
                    end
                    P_HOLD: begin
                        if (fall) begin ph[i] = P_IDLE; t_ent[i] = cyc; end
                        else if (cyc - t_rep[i] == REP_C) begin r = 1; t_rep[i] = cyc; end
                    end
                    P_GAP: begin
                        if (rise) begin ph[i] = P_AGAIN; t_ent[i] = cyc; end
                        else if (el == DCL_C) begin ph[i] = P_IDLE; s = 1; t_ent[i] = cyc; end
                    end
                    default: begin
                        if (fall) begin ph[i] = P_IDLE; d = 1; t_ent[i] = cyc; end
                        else if (el == LONG_C) begin
                            ph[i] = P_HOLD; l = 1; t_ent[i] = cyc; t_rep[i] = cyc;
                        end
                    end
                endcase
                exp_o[i] = {s, d, l, r, (ph[i] == P_DOWN || ph[i] == P_HOLD || ph[i] == P_AGAIN)};
                m_prev[i] = b;
                m_arm[i] = m_arm[i] | !b;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int n_printed = 0;
    int cnt[4][2];
    int last[4][2];
    int base[4][2];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_printed < 40) begin
                n_printed++;
                $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, cyc);
            end
        end
    endtask

    function automatic int out_vec(input int i);
        if (i == 0)
            return int'({bus_a.o_short_pulse, bus_a.o_double_pulse, bus_a.o_long_pulse,
                          bus_a.o_repeat_pulse, bus_a.o_held});
        return int'({bus_b.o_short_pulse, bus_b.o_double_pulse, bus_b.o_long_pulse,
                      bus_b.o_repeat_pulse, bus_b.o_held});
    endfunction

    function automatic int dlt(input int t, input int i);
        return cnt[t][i] - base[t][i];
    endfunction

    task automatic step(input int n);
        int v;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                v = out_vec(i);
                check(i == 0 ? "outputs{s,d,l,r,held} dclick_on" : "outputs{s,d,l,r,held} dclick_off",
                      v, int'(exp_o[i]));
                for (int t = 0; t < 4; t++) begin
                    if (v[4 - t]) begin cnt[t][i]++; last[t][i] = cyc; end
                end
            end
        end
    endtask

    task automatic hold(input bit v, input int n);
        btn = v;
        step(n);
    endtask

    int e, f, p, g;

    initial begin
        for (int t = 0; t < 4; t++) for (int i = 0; i < 2; i++) begin cnt[t][i] = 0; last[t][i] = -1; end
        step(3);
        check("reset outputs on", out_vec(0), 0);
        check("reset outputs off", out_vec(1), 0);
        reset = 1'b1;
        hold(0, 10);

        // Single short click
        base = cnt;
        hold(1, 25);
        check("held mid-press", int'(bus_a.o_held), 1);
        hold(1, 25);
        f = cyc + 1;
        hold(0, 200);
        check("short count on", dlt(0, 0), 1);
        check("short delay on", last[0][0] - f, 60);
        check("short delay off", last[0][1] - f, 0);
        check("other pulses on", dlt(1, 0) + dlt(2, 0) + dlt(3, 0), 0);

        // Double click
        base = cnt;
        hold(1, 30); hold(0, 20); hold(1, 30);
        f = cyc + 1;
        hold(0, 100);
        check("double count on", dlt(1, 0), 1);
        check("double delay on", last[1][0] - f, 0);
        check("short none on dbl", dlt(0, 0), 0);
        check("short count off dbl", dlt(0, 1), 2);

        // Long hold with repeats
        base = cnt;
        e = cyc + 1;
        hold(1, 320);
        hold(0, 5);
        check("held after long release", int'(bus_a.o_held), 0);
        hold(0, 100);
        check("long at 200", last[2][0] - e, 200);
        check("repeat count", dlt(3, 0), 2);
        check("last repeat at 300", last[3][0] - e, 300);
        check("no short after long", dlt(0, 0) + dlt(1, 0), 0);

        // Release on the long boundary
        base = cnt;
        e = cyc + 1;
        hold(1, 200);
        f = cyc + 1;
        hold(0, 100);
        check("boundary no long on", dlt(2, 0), 0);
        check("boundary short on", last[0][0] - f, 60);
        check("boundary no long off", dlt(2, 1), 0);
        check("boundary short off", last[0][1] - f, 0);

        // Second press 5 cycles after release
        base = cnt;
        hold(1, 50); hold(0, 5); hold(1, 50); hold(0, 100);
        check("two shorts off", dlt(0, 1), 2);
        check("no double off", dlt(1, 1), 0);
        check("double on", dlt(1, 0), 1);

        // Second press exactly at / one past the double-click window
        base = cnt;
        hold(1, 30); hold(0, 60); hold(1, 30); hold(0, 100);
        check("rise on window edge double", dlt(1, 0), 1);
        check("rise on window edge no short", dlt(0, 0), 0);
        base = cnt;
        hold(1, 30); hold(0, 61); hold(1, 30); hold(0, 100);
        check("late rise shorts", dlt(0, 0), 2);
        check("late rise no double", dlt(1, 0), 0);

        // Reset during long hold while the button stays down
        hold(1, 230);
        check("held before reset", int'(bus_a.o_held), 1);
        reset = 1'b0;
        #1;
        check("async reset outputs on", out_vec(0), 0);
        check("async reset outputs off", out_vec(1), 0);
        step(3);
        reset = 1'b1;
        base = cnt;
        hold(1, 300);
        check("no pulses after reset on", dlt(0, 0) + dlt(1, 0) + dlt(2, 0) + dlt(3, 0), 0);
        check("no pulses after reset off", dlt(0, 1) + dlt(1, 1) + dlt(2, 1) + dlt(3, 1), 0);
        check("not held after reset", int'(bus_a.o_held), 0);
        hold(0, 20);
        base = cnt;
        hold(1, 50);
        f = cyc + 1;
        hold(0, 100);
        check("short after re-arm", last[0][0] - f, 60);

        // Randomised press/release sequences, biased toward the timing boundaries
        for (int k = 0; k < 40; k++) begin
            p = ($urandom_range(0, 3) == 0) ? 199 + int'($urandom_range(0, 2)) : int'($urandom_range(1, 330));
            g = ($urandom_range(0, 3) == 0) ? 59 + int'($urandom_range(0, 2)) : int'($urandom_range(1, 90));
            hold(1, p);
            hold(0, g);
        end
        hold(0, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
